arc4_key_search: RTL and testbench

Brute-force key sequencer that sits directly upstream of the `arc4` decryption core. It drives `arc4`'s `en`/`key` handshake and sweeps a 24-bit key range. It snoops the plaintext write port that `arc4` drives and classifies each candidate key as readable or not. It reports the first key whose entire decrypted message, excluding the length byte, is printable ASCII.

---
 rtl/arc4_key_search.sv | 145 ++++++++++++++
 tb/tb_arc4_key_search.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_key_search.sv
// arc4_key_search: sweeps a 24-bit key range through arc4 and reports the first key whose plaintext is printable ASCII.
// Optional feature KEY_SEARCH_ABORT_EN adds arc_abort, which cuts a candidate short on its first bad byte.
module arc4_key_search #(
   parameter logic [23:0] KEY_FIRST = 24'h000000,
   parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        rdy,
   output logic        key_valid,
   output logic [23:0] key,
   output logic        arc_en,
   input  logic        arc_rdy,
   output logic [23:0] arc_key,
   input  logic [7:0]  mon_pt_addr,
   input  logic [7:0]  mon_pt_wrdata,
   input  logic        mon_pt_wren
`ifdef KEY_SEARCH_ABORT_EN
   ,
   output logic        arc_abort
`endif
);

   localparam int unsigned KEY_W  = 24;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_RUN,
      S_EVAL
`ifdef KEY_SEARCH_ABORT_EN
      ,
      S_ABORT
`endif
   } state_e;

   state_e             state_q, state_d;
   logic               rdy_q, rdy_d;
   logic               key_valid_q, key_valid_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [KEY_W-1:0]   arc_key_q, arc_key_d;
   logic               bad_q, bad_d;
   logic               bad_wr;
   logic               last_key;

   // Length byte at address 0 is exempt from the printable check.
   assign bad_wr = mon_pt_wren && (mon_pt_addr != BYTE_W'(0)) &&
                   ((mon_pt_wrdata < BYTE_W'(8'h20)) || (mon_pt_wrdata > BYTE_W'(8'h7E)));
   assign last_key = (arc_key_q == KEY_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rdy_q       <= 1'b1;
         key_valid_q <= 1'b0;
         key_q       <= '0;
         arc_key_q   <= KEY_FIRST;
         bad_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         key_valid_q <= key_valid_d;
         key_q       <= key_d;
         arc_key_q   <= arc_key_d;
         bad_q       <= bad_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rdy_d       = rdy_q;
      key_valid_d = key_valid_q;
      key_d       = key_q;
      arc_key_d   = arc_key_q;
      bad_d       = bad_q;
      arc_en      = 1'b0;
`ifdef KEY_SEARCH_ABORT_EN
      arc_abort   = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d     = S_LAUNCH;
               arc_key_d   = KEY_FIRST;
               key_valid_d = 1'b0;
               key_d       = '0;
            end
         end
         S_LAUNCH: begin
            if (arc_rdy) begin
               arc_en  = 1'b1;
               bad_d   = 1'b0;
               state_d = S_WAIT_BUSY;
            end
         end
         // Skips arc4's lingering ready until it actually goes busy.
         S_WAIT_BUSY: begin
            if (bad_wr) bad_d = 1'b1;
            if (!arc_rdy) state_d = S_RUN;
         end
         S_RUN: begin
            if (bad_wr) bad_d = 1'b1;
`ifdef KEY_SEARCH_ABORT_EN
            if (bad_wr || bad_q) state_d = S_ABORT;
            else
`endif
            if (arc_rdy) state_d = S_EVAL;
         end
         S_EVAL: begin
            if (!bad_q) begin
               key_d       = arc_key_q;
               key_valid_d = 1'b1;
               state_d     = S_IDLE;
            end else if (last_key) begin
               state_d = S_IDLE;
            end else begin
               arc_key_d = arc_key_q + KEY_W'(1);
               state_d   = S_LAUNCH;
            end
         end
`ifdef KEY_SEARCH_ABORT_EN
         S_ABORT: begin
            arc_abort = 1'b1;
            if (last_key) begin
               state_d = S_IDLE;
            end else begin
               arc_key_d = arc_key_q + KEY_W'(1);
               state_d   = S_LAUNCH;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
      rdy_d = (state_d == S_IDLE);
   end

   assign rdy       = rdy_q;
   assign key_valid = key_valid_q;
   assign key       = key_q;
   assign arc_key   = arc_key_q;

endmodule

// File: tb/tb_arc4_key_search.sv
// Bench for arc4_key_search: behavioural arc4 stand-in, table vectors, random messages and hand-written corner sequences.
`timescale 1ns/1ps
module tb_arc4_key_search;

   localparam logic [23:0] KF = 24'h000000;
   localparam logic [23:0] KL = 24'h000003;
   localparam int NK   = 4;
   localparam int MAXB = 8;

   logic        clk = 1'b0;
   logic        rst, en, rdy, key_valid, arc_en, arc_rdy, mon_pt_wren;
   logic [23:0] key, arc_key;
   logic [7:0]  mon_pt_addr, mon_pt_wrdata;
   logic        abort_w;
`ifdef KEY_SEARCH_ABORT_EN
   logic        arc_abort;
   assign abort_w = arc_abort;
`else
   assign abort_w = 1'b0;
`endif

   arc4_key_search #(.KEY_FIRST(KF), .KEY_LAST(KL)) u_dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key_valid(key_valid), .key(key),
      .arc_en(arc_en), .arc_rdy(arc_rdy), .arc_key(arc_key),
      .mon_pt_addr(mon_pt_addr), .mon_pt_wrdata(mon_pt_wrdata), .mon_pt_wren(mon_pt_wren)
`ifdef KEY_SEARCH_ABORT_EN
      , .arc_abort(arc_abort)
`endif
   );

   always #5 clk = ~clk;

   // Message store: bytes for addresses 1..len per key; address 0 carries len.
   logic [7:0]  msg_mem [NK][MAXB];
   int          msg_len [NK];
   bit          coinc    = 1'b0;
   bit          hold_rdy = 1'b0;
   logic [23:0] launches[$];
   int          proto_err = 0, abort_cycles = 0, wr_count = 0;
   int          tests = 0, fails = 0;

   typedef struct {
      string               name;
      logic [NK-1:0][63:0] data;
      logic [NK-1:0][3:0]  len;
      bit                  coinc;
      bit                  exp_v;
      logic [23:0]         exp_k;
      int                  exp_nl;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural arc4: lingering ready, busy, plaintext writes, ready again.
   task automatic run_cand(input logic [23:0] k);
      int idx;
      idx = int'(k) - int'(KF);
      if (idx < 0 || idx >= NK) idx = 0;
      launches.push_back(k);
      @(negedge clk);
      if (rst) begin arc_rdy = 1'b1; return; end
      arc_rdy = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (rst || abort_w) begin arc_rdy = 1'b1; return; end
      end
      for (int j = 0; j <= msg_len[idx]; j++) begin
         @(negedge clk);
         if (rst || abort_w) begin mon_pt_wren = 1'b0; arc_rdy = 1'b1; return; end
         mon_pt_wren   = 1'b1;
         mon_pt_addr   = 8'(j);
         mon_pt_wrdata = (j == 0) ? 8'(msg_len[idx]) : msg_mem[idx][j-1];
         if (coinc && j == msg_len[idx]) arc_rdy = 1'b1;
      end
      @(negedge clk);
      mon_pt_wren = 1'b0;
      arc_rdy     = 1'b1;
   endtask

   initial begin
      arc_rdy = 1'b1; mon_pt_wren = 1'b0; mon_pt_addr = '0; mon_pt_wrdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            arc_rdy = 1'b1; mon_pt_wren = 1'b0;
         end else begin
            arc_rdy = !hold_rdy;
            #1;
            if (arc_en) run_cand(arc_key);
         end
      end
   end

   // Launch protocol watcher: single-cycle pulses, only with arc_rdy, key inside range.
   always @(negedge clk) begin
      static bit prev_en = 1'b0;
      #2;
      if (arc_en && (!arc_rdy || prev_en || arc_key > KL || arc_key < KF)) proto_err++;
      if (abort_w) abort_cycles++;
      if (mon_pt_wren) wr_count++;
      prev_en = arc_en;
   end

   function automatic void ref_search(output bit v, output logic [23:0] k, output int nl);
      bit ok;
      v = 1'b0; k = '0; nl = 0;
      for (int c = 0; c < NK; c++) begin
         nl++;
         ok = 1'b1;
         for (int j = 0; j < msg_len[c]; j++)
            if (msg_mem[c][j] < 8'h20 || msg_mem[c][j] > 8'h7E) ok = 1'b0;
         if (ok) begin v = 1'b1; k = KF + 24'(c); return; end
      end
   endfunction

   task automatic load_vec(input vec_t v);
      for (int c = 0; c < NK; c++) begin
         msg_len[c] = int'(v.len[c]);
         for (int j = 0; j < MAXB; j++) msg_mem[c][j] = v.data[c][8*j +: 8];
      end
      coinc = v.coinc;
   endtask

   task automatic wait_rdy(input string name);
      int c = 0;
      while (!rdy && c < 3000) begin @(negedge clk); c++; end
      check({name, " timeout"}, 32'(c < 3000), 32'd1);
   endtask

   task automatic check_result(input string name, input bit ev, input logic [23:0] ek, input int enl);
      int nbad = 0;
      check({name, " key_valid"}, 32'(key_valid), 32'(ev));
      check({name, " key"}, 32'(key), 32'(ek));
      check({name, " launches"}, 32'(launches.size()), 32'(enl));
      for (int i = 0; i < launches.size(); i++)
         if (launches[i] !== KF + 24'(i)) nbad++;
      check({name, " launch order"}, 32'(nbad), 32'd0);
   endtask

   task automatic do_search(input string name, input bit ev, input logic [23:0] ek, input int enl);
      launches.delete();
      @(negedge clk); en = 1'b1;
      @(negedge clk); en = 1'b0;
      check({name, " rdy drop"}, 32'(rdy), 32'd0);
      wait_rdy(name);
      check_result(name, ev, ek, enl);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rv;
      logic [23:0] rk;
      int          rn, base_ab, base_wr;
      logic [7:0]  r8;

      vecs[0] = '{name:"found",  data:{64'h6B6F, 64'h216948, 64'h01, 64'h01},
                  len:{4'd2, 4'd3, 4'd1, 4'd1}, coinc:1'b0, exp_v:1'b1, exp_k:24'd2, exp_nl:3};
      vecs[1] = '{name:"edge_ok", data:{64'h01, 64'h01, 64'h01, 64'h7E20},
                  len:{4'd1, 4'd1, 4'd1, 4'd2}, coinc:1'b0, exp_v:1'b1, exp_k:24'd0, exp_nl:1};
      vecs[2] = '{name:"addr5",  data:{64'h01, 64'h41_4141_4141, 64'h7F_4141_4141, 64'h1F_4141_4141},
                  len:{4'd1, 4'd5, 4'd5, 4'd5}, coinc:1'b0, exp_v:1'b1, exp_k:24'd2, exp_nl:3};
      vecs[3] = '{name:"exhaust", data:{64'h7F, 64'h7F, 64'h7F, 64'h7F},
                  len:{4'd1, 4'd1, 4'd1, 4'd1}, coinc:1'b0, exp_v:1'b0, exp_k:24'd0, exp_nl:4};
      vecs[4] = '{name:"coinc",  data:{64'h01, 64'h01, 64'h7E, 64'h1F41},
                  len:{4'd1, 4'd1, 4'd1, 4'd2}, coinc:1'b1, exp_v:1'b1, exp_k:24'd1, exp_nl:2};
      vecs[5] = '{name:"lenbyte", data:{64'h01, 64'h01, 64'h01, 64'h7E7E7E7E7E7E7E7E},
                  len:{4'd1, 4'd1, 4'd1, 4'd8}, coinc:1'b0, exp_v:1'b1, exp_k:24'd0, exp_nl:1};

      rst = 1'b1; en = 1'b0;
      load_vec(vecs[3]);
      repeat (3) @(negedge clk);
      check("reset rdy", 32'(rdy), 32'd1);
      check("reset key_valid", 32'(key_valid), 32'd0);
      check("reset key", 32'(key), 32'd0);
      check("reset arc_key", 32'(arc_key), 32'(KF));
      check("reset arc_en", 32'(arc_en), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         load_vec(vecs[i]);
         do_search(vecs[i].name, vecs[i].exp_v, vecs[i].exp_k, vecs[i].exp_nl);
      end

      // Launch held off by arc4 not ready; en while busy must be ignored.
      load_vec(vecs[0]);
      launches.delete();
      @(negedge clk); hold_rdy = 1'b1;
      @(negedge clk); en = 1'b1;
      @(negedge clk); en = 1'b0;
      repeat (4) @(negedge clk);
      en = 1'b1;
      @(negedge clk); en = 1'b0;
      repeat (5) @(negedge clk);
      check("hold no launch", 32'(launches.size()), 32'd0);
      check("hold rdy low", 32'(rdy), 32'd0);
      hold_rdy = 1'b0;
      wait_rdy("hold");
      check_result("hold", 1'b1, 24'd2, 3);

      // Reset while key 1 is running, then a fresh sweep from KEY_FIRST.
      msg_len[0] = 1; msg_mem[0][0] = 8'h7F;
      msg_len[1] = 8;
      for (int j = 0; j < MAXB; j++) msg_mem[1][j] = 8'h41;
      coinc = 1'b0;
      launches.delete();
      @(negedge clk); en = 1'b1;
      @(negedge clk); en = 1'b0;
      for (int c = 0; c < 500 && launches.size() < 2; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst rdy", 32'(rdy), 32'd1);
      check("midrst key_valid", 32'(key_valid), 32'd0);
      check("midrst arc_key", 32'(arc_key), 32'(KF));
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      do_search("restart", 1'b1, 24'd1, 2);

`ifdef KEY_SEARCH_ABORT_EN
      msg_len[0] = 8; msg_mem[0][0] = 8'h1F;
      for (int j = 1; j < MAXB; j++) msg_mem[0][j] = 8'h41;
      msg_len[1] = 1; msg_mem[1][0] = 8'h41;
      coinc   = 1'b0;
      base_ab = abort_cycles;
      base_wr = wr_count;
      do_search("abort", 1'b1, 24'd1, 2);
      check("abort pulse cycles", 32'(abort_cycles - base_ab), 32'd1);
      check("abort writes", 32'(wr_count - base_wr), 32'd4);
`endif

      for (int it = 0; it < 15; it++) begin
         for (int c = 0; c < NK; c++) begin
            msg_len[c] = $urandom_range(1, MAXB);
            for (int j = 0; j < MAXB; j++) begin
               case ($urandom_range(0, 15))
                  0:       r8 = 8'h1F;
                  1:       r8 = 8'h7F;
                  2:       r8 = 8'h20;
                  3:       r8 = 8'h7E;
                  default: r8 = 8'($urandom_range(32, 126));
               endcase
               msg_mem[c][j] = r8;
            end
         end
         coinc = 1'($urandom_range(0, 1));
         ref_search(rv, rk, rn);
         do_search($sformatf("rand%0d", it), rv, rk, rn);
      end

      repeat (3) @(negedge clk);
      check("launch protocol", 32'(proto_err), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
